// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle (shift-add multiply, restoring divide) on
// operand magnitudes; a final cycle applies sign correction and writes HI/LO.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start; MTLO/MTHI write LO/HI directly
//   S_CALC | one iteration per cycle, counter WIDTH-1 down to 0
//   S_FIX  | sign correction, HI/LO (and div_zero) written, back to idle
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             flush,
  input  logic             rd_hi,
  output logic [WIDTH-1:0] data_out,
  output logic             run,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;
  logic               r_is_div;
  logic               r_neg_res;   // quotient/product must be negated
  logic               r_neg_a;     // remainder takes the dividend's sign
  logic [WIDTH-1:0]   r_raw_a;     // original dividend, returned in HI on /0
  logic [WIDTH-1:0]   r_b;         // divisor/multiplier magnitude
  logic [2*WIDTH-1:0] r_acc;       // {partial/remainder, multiplier/quotient}

  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_b_zero;

  // Operand sign handling: op[0] selects the signed variant.
  always_comb begin
    w_neg_a = op[0] & src_a[WIDTH-1];
    w_neg_b = op[0] & src_b[WIDTH-1];
    w_mag_a = w_neg_a ? -src_a : src_a;
    w_mag_b = w_neg_b ? -src_b : src_b;
  end

  // Next-iteration values for multiply and divide, plus final sign fix-up.
  always_comb begin
    w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_mul_next = {w_add, r_acc[WIDTH-1:1]};
    w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff     = w_rem_sh - {1'b0, r_b};
    w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                               : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
    w_prod     = r_neg_res ? -r_acc : r_acc;
    w_quo      = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem      = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_b_zero   = (r_b == {WIDTH{1'b0}});
  end

  // Sequencer, iteration datapath and HI/LO result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_a    <= 1'b0;
      r_raw_a    <= '0;
      r_b        <= '0;
      r_acc      <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (op[2] == 1'b0) begin
                r_is_div  <= op[1];
                r_neg_res <= w_neg_a ^ w_neg_b;
                r_neg_a   <= w_neg_a;
                r_raw_a   <= src_a;
                r_b       <= w_mag_b;
                r_acc     <= {{WIDTH{1'b0}}, w_mag_a};
                r_cnt     <= CW'(WIDTH-1);
                r_state   <= S_CALC;
              end else if (op[1] == 1'b0) begin
                if (op[0]) r_hi <= src_a;
                else       r_lo <= src_a;
              end
            end
          end
          S_CALC: begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - CW'(1);
          end
          S_FIX: begin
            if (!r_is_div) begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end else if (w_b_zero) begin
              r_hi       <= r_raw_a;
              r_lo       <= {WIDTH{1'b1}};
              r_div_zero <= 1'b1;
            end else begin
              r_hi       <= w_rem;
              r_lo       <= w_quo;
              r_div_zero <= 1'b0;
            end
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign data_out = rd_hi ? r_hi : r_lo;
  assign run      = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a WIDTH=32 instance for the main function,
// aborts and conflicts, and a WIDTH=8 instance for the narrow-width cases.
module tb_muldiv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic        a_reset, a_start, a_flush, a_rd_hi;
  logic [2:0]  a_op;
  logic [31:0] a_src_a, a_src_b, a_dout;
  logic        a_run, a_done, a_dz;

  logic        b_reset, b_start, b_flush, b_rd_hi;
  logic [2:0]  b_op;
  logic [7:0]  b_src_a, b_src_b, b_dout;
  logic        b_run, b_done, b_dz;

  muldiv_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(a_reset), .src_a(a_src_a), .src_b(a_src_b), .op(a_op),
    .start(a_start), .flush(a_flush), .rd_hi(a_rd_hi), .data_out(a_dout),
    .run(a_run), .done(a_done), .div_zero(a_dz)
  );

  muldiv_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(b_reset), .src_a(b_src_a), .src_b(b_src_b), .op(b_op),
    .start(b_start), .flush(b_flush), .rd_hi(b_rd_hi), .data_out(b_dout),
    .run(b_run), .done(b_done), .div_zero(b_dz)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic a_hilo(output logic [31:0] hi, output logic [31:0] lo);
    a_rd_hi = 1'b1; #1; hi = a_dout;
    a_rd_hi = 1'b0; #1; lo = a_dout;
  endtask

  task automatic b_hilo(output logic [7:0] hi, output logic [7:0] lo);
    b_rd_hi = 1'b1; #1; hi = b_dout;
    b_rd_hi = 1'b0; #1; lo = b_dout;
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic a_start_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    a_op = op; a_src_a = x; a_src_b = y; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic b_start_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    b_op = op; b_src_a = x; b_src_b = y; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
  endtask

  // Counts cycles with run high; optionally injects a start or a flush on run cycle k.
  task automatic a_run_cnt(input int inj_at, input int flush_at, output int n);
    n = 0;
    while (a_run === 1'b1 && n < 200) begin
      n++;
      a_start = (n == inj_at);
      if (n == inj_at) begin a_op = 3'b000; a_src_a = 32'd3; a_src_b = 32'd3; end
      a_flush = (n == flush_at);
      @(negedge clk);
    end
    a_start = 1'b0;
    a_flush = 1'b0;
  endtask

  task automatic b_run_cnt(output int n);
    n = 0;
    while (b_run === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic a_mdop(input string tag, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz);
    int n;
    logic [31:0] hi, lo;
    a_start_op(op, x, y);
    a_run_cnt(0, 0, n);
    chk({tag, " run_cycles"}, 64'(n), 64'd33);
    chk({tag, " done"}, 64'(a_done), 64'd1);
    a_hilo(hi, lo);
    chk({tag, " hi"}, 64'(hi), 64'(ehi));
    chk({tag, " lo"}, 64'(lo), 64'(elo));
    chk({tag, " div_zero"}, 64'(a_dz), 64'(edz));
    @(negedge clk);
    chk({tag, " done_pulse_end"}, 64'(a_done), 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] hi, lo;
    logic [7:0]  bhi, blo;

    a_reset = 1'b1; a_start = 1'b0; a_flush = 1'b0; a_rd_hi = 1'b0;
    a_op = 3'b000; a_src_a = '0; a_src_b = '0;
    b_reset = 1'b1; b_start = 1'b0; b_flush = 1'b0; b_rd_hi = 1'b0;
    b_op = 3'b000; b_src_a = '0; b_src_b = '0;
    @(negedge clk);
    @(negedge clk);
    a_hilo(hi, lo);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst run", 64'(a_run), 64'd0);
    chk("rst done", 64'(a_done), 64'd0);
    chk("rst div_zero", 64'(a_dz), 64'd0);
    a_reset = 1'b0;
    b_reset = 1'b0;
    @(negedge clk);

    // Main function, WIDTH=32
    a_mdop("multu_max", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    a_mdop("mult_neg",  3'b001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    a_mdop("div_neg",   3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    a_mdop("divu_zero", 3'b010, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1);
    a_mdop("multu_dzhold", 3'b000, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);
    a_mdop("divu_9_4",  3'b010, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);
    a_mdop("div_ovf",   3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    a_mdop("div_zero_s", 3'b011, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

    // MTLO / MTHI: immediate write, no run, no done, div_zero held
    a_start_op(3'b100, 32'h00001234, 32'd0);
    chk("mtlo run", 64'(a_run), 64'd0);
    chk("mtlo done", 64'(a_done), 64'd0);
    a_start_op(3'b101, 32'h00000055, 32'd0);
    a_hilo(hi, lo);
    chk("mthi hi", 64'(hi), 64'h55);
    chk("mtlo lo", 64'(lo), 64'h1234);
    chk("mtxx div_zero_hold", 64'(a_dz), 64'd1);

    // Flush at run cycle 10
    a_start_op(3'b010, 32'd100, 32'd7);
    a_run_cnt(0, 10, n);
    chk("flush run_cycles", 64'(n), 64'd10);
    chk("flush run", 64'(a_run), 64'd0);
    chk("flush done", 64'(a_done), 64'd0);
    a_hilo(hi, lo);
    chk("flush lo", 64'(lo), 64'h1234);
    chk("flush hi", 64'(hi), 64'h55);
    chk("flush div_zero", 64'(a_dz), 64'd1);
    @(negedge clk);
    chk("flush no_done", 64'(a_done), 64'd0);

    // Second start mid-run is ignored
    a_start_op(3'b010, 32'd100, 32'd7);
    a_run_cnt(5, 0, n);
    chk("restart run_cycles", 64'(n), 64'd33);
    chk("restart done", 64'(a_done), 64'd1);
    a_hilo(hi, lo);
    chk("restart lo", 64'(lo), 64'd14);
    chk("restart hi", 64'(hi), 64'd2);
    chk("restart div_zero", 64'(a_dz), 64'd0);
    @(negedge clk);

    // Flush in FIX: nothing written, no done
    a_start_op(3'b010, 32'd8, 32'd0);
    a_run_cnt(0, 33, n);
    chk("fixflush run_cycles", 64'(n), 64'd33);
    chk("fixflush done", 64'(a_done), 64'd0);
    a_hilo(hi, lo);
    chk("fixflush lo", 64'(lo), 64'd14);
    chk("fixflush hi", 64'(hi), 64'd2);
    chk("fixflush div_zero", 64'(a_dz), 64'd0);
    @(negedge clk);
    chk("fixflush no_done", 64'(a_done), 64'd0);

    // data_out shows old values during run
    a_start_op(3'b000, 32'd7, 32'd7);
    chk("oldval run", 64'(a_run), 64'd1);
    chk("oldval lo", 64'(a_dout), 64'd14);
    a_run_cnt(0, 0, n);
    chk("mul7 run_cycles", 64'(n), 64'd33);
    a_hilo(hi, lo);
    chk("mul7 lo", 64'(lo), 64'd49);
    chk("mul7 hi", 64'(hi), 64'd0);
    @(negedge clk);

    // flush + start on the same edge
    a_op = 3'b000; a_src_a = 32'd2; a_src_b = 32'd2; a_start = 1'b1; a_flush = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_flush = 1'b0;
    chk("flushstart run", 64'(a_run), 64'd0);
    a_op = 3'b100; a_src_a = 32'hDEAD; a_start = 1'b1; a_flush = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_flush = 1'b0;
    chk("flushmtlo lo", 64'(a_dout), 64'd49);
    chk("flushstart done", 64'(a_done), 64'd0);

    // Reserved ops ignored
    a_start_op(3'b110, 32'd1, 32'd1);
    chk("rsv110 run", 64'(a_run), 64'd0);
    a_start_op(3'b111, 32'd1, 32'd1);
    chk("rsv111 run", 64'(a_run), 64'd0);
    a_hilo(hi, lo);
    chk("rsv lo", 64'(lo), 64'd49);
    chk("rsv hi", 64'(hi), 64'd0);

    // WIDTH=8 instance
    b_start_op(3'b001, 8'h80, 8'h80);
    b_run_cnt(n);
    chk("w8 mult run_cycles", 64'(n), 64'd9);
    chk("w8 mult done", 64'(b_done), 64'd1);
    b_hilo(bhi, blo);
    chk("w8 mult hi", 64'(bhi), 64'h40);
    chk("w8 mult lo", 64'(blo), 64'h00);
    @(negedge clk);
    b_start_op(3'b010, 8'h03, 8'h00);
    b_run_cnt(n);
    b_hilo(bhi, blo);
    chk("w8 divz hi", 64'(bhi), 64'h03);
    chk("w8 divz lo", 64'(blo), 64'hFF);
    chk("w8 divz div_zero", 64'(b_dz), 64'd1);
    @(negedge clk);
    b_start_op(3'b000, 8'hFF, 8'hFF);
    repeat (3) @(negedge clk);
    chk("w8 midcalc run", 64'(b_run), 64'd1);
    b_reset = 1'b1;
    @(negedge clk);
    b_reset = 1'b0;
    chk("w8 rst run", 64'(b_run), 64'd0);
    chk("w8 rst done", 64'(b_done), 64'd0);
    chk("w8 rst div_zero", 64'(b_dz), 64'd0);
    b_hilo(bhi, blo);
    chk("w8 rst hi", 64'(bhi), 64'd0);
    chk("w8 rst lo", 64'(blo), 64'd0);
    repeat (8) @(negedge clk);
    chk("w8 rst no_done", 64'(b_done), 64'd0);
    chk("w8 rst lo_stays", 64'(b_dout), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
- REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width; legal values 4..64.
- REQ-002 clk  input  1  rising-edge clock for all state.
- REQ-003 reset  input  1  synchronous, active-high reset.
- REQ-004 src_a  input  WIDTH  operand A: dividend, multiplicand, or MTHI/MTLO data.
- REQ-005 src_b  input  WIDTH  operand B: divisor or multiplier.
- REQ-006 op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTLO, 101 MTHI, 11x reserved (start ignored).
- REQ-007 start  input  1  request; sampled on a rising edge, with op/src_a/src_b on that same edge.
- REQ-008 flush  input  1  synchronous abort of any in-flight operation.
- REQ-009 rd_hi  input  1  read select: 1 selects HI, 0 selects LO.
- REQ-010 data_out  output  WIDTH  combinational: rd_hi ? HI : LO.
- REQ-011 run  output  1  high while an operation is in flight.
- REQ-012 done  output  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- REQ-013 div_zero  output  1  high when the last completed divide had src_b == 0.

Function
- REQ-014 FSM states: IDLE, CALC, FIX; run SHALL be 1 exactly when state is CALC or FIX.
- REQ-015 IDLE, start, op 0xx: latch operands; latch sign flags for MULT/DIV; take magnitudes for MULT/DIV, raw values for MULTU/DIVU; go to CALC; iteration counter = WIDTH-1.
- REQ-016 CALC: one iteration per cycle for WIDTH cycles (counter down to 0), then go to FIX.
- REQ-017 Multiply iteration: radix-2 shift-add on magnitudes into a 2*WIDTH accumulator.
- REQ-018 Divide iteration: radix-2 restoring divide on magnitudes.
- REQ-019 FIX (1 cycle): apply sign correction, write HI/LO, go to IDLE; done = 1 in the following cycle only.
- REQ-020 Latency: run high for exactly WIDTH+1 cycles; HI/LO hold the new values in the cycle where done = 1.
- REQ-021 Product: {HI,LO} = full 2*WIDTH product; MULT negates the product when the operand signs differ.
- REQ-022 Divide: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- REQ-023 Divide by zero (signed or unsigned): LO = all ones, HI = src_a unchanged, div_zero = 1.
- REQ-024 div_zero SHALL be 0 after any non-zero divide; it holds across MULT/MTxx operations.
- REQ-025 Signed overflow (MIN / -1): LO = MIN, HI = 0, div_zero = 0.
- REQ-026 IDLE, start, op 10x: write src_a to LO (100) or HI (101) on that edge; run stays 0; no done.
- REQ-027 start while run = 1 SHALL be ignored; latched operands and progress are unaffected.
- REQ-028 flush = 1: state goes to IDLE on that edge; HI/LO/div_zero unchanged; no done, including a flush in FIX.
- REQ-029 flush and start on the same edge: flush wins and start is discarded.
- REQ-030 data_out SHALL reflect HI/LO at all times, including during run (old values until FIX writes).

Reset
- REQ-031 reset SHALL have priority over flush and start.
- REQ-032 On reset: state IDLE, HI = 0, LO = 0, run = 0, done = 0, div_zero = 0, counter = 0.
- REQ-033 Reset mid-operation: the result is discarded and the outputs above take their reset values on the next edge.

Verification (WIDTH = 32 unless stated)
- REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> run high 33 cycles, then done pulse; HI = 0xFFFFFFFE, LO = 0x00000001.
- REQ-035 MULT 0xFFFFFFFD x 0x00000005 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; DIV 0xFFFFFFF9 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- REQ-036 DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 0x00000005, div_zero = 1; then DIVU 9 / 4 -> LO = 2, HI = 1, div_zero = 0.
- REQ-037 DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0x00000000.
- REQ-038 Aborts and conflicts:
  - MTLO 0x1234, then DIVU, then flush at run cycle 10 -> run = 0 next cycle, LO = 0x1234, no done.
  - A second start mid-run -> ignored.
  - flush + start on the same edge -> nothing started.
- REQ-039 WIDTH = 8: MULT 0x80 x 0x80 -> HI = 0x40, LO = 0x00, run high 9 cycles; reset asserted mid-CALC -> all outputs 0 next cycle.
